// File: rtl/mem_stage.sv
// Memory stage: drives a single-outstanding data bus request for loads/stores,
// formats load data and registers the MEM/WB results.
module mem_stage #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   mem_wd,
  input  logic [31:0]                  mem_wdata,
  input  logic                         mem_wreg,
  input  logic                         mem_whilo,
  input  logic [31:0]                  mem_hi,
  input  logic [31:0]                  mem_lo,
  input  logic [2:0]                   mem_op,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_sdata,
  output logic                         dbus_req,
  output logic                         dbus_we,
  output logic [31:0]                  dbus_addr,
  output logic [NUM_LANES-1:0]         dbus_be,
  output logic [31:0]                  dbus_wdata,
  input  logic                         dbus_ack,
  input  logic [31:0]                  dbus_rdata,
  output logic                         stallreq,
  output logic                         excp_adel,
  output logic                         excp_ades,
  output logic [4:0]                   wb_wd,
  output logic [31:0]                  wb_wdata,
  output logic                         wb_wreg,
  output logic                         wb_whilo,
  output logic [31:0]                  wb_hi,
  output logic [31:0]                  wb_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  state_t      state;
  logic [31:0] load_q;

  logic is_word, is_byte, is_store, is_load, valid_acc;
  logic [NUM_LANES-1:0] be_nxt;
  logic [31:0] wdata_nxt, sb_rep, load_fmt;
  logic [VEC_W-1:0] lane_byte;

  assign is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
  assign is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
  assign is_store = (mem_op == OP_SW) || (mem_op == OP_SB);
  assign is_load  = (mem_op == OP_LW) || (mem_op == OP_LB) || (mem_op == OP_LBU);

  assign excp_adel = (mem_op == OP_LW) && (mem_addr[1:0] != 2'b00);
  assign excp_ades = (mem_op == OP_SW) && (mem_addr[1:0] != 2'b00);
  assign valid_acc = (is_word && (mem_addr[1:0] == 2'b00)) || is_byte;

  assign stallreq = ((state == IDLE) && valid_acc) || (state == BUSY);

  // Store byte replicated onto every lane; byte enables pick the real target.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign sb_rep[i*VEC_W +: VEC_W] = mem_sdata[VEC_W-1:0];
  end

  assign be_nxt    = is_word ? {NUM_LANES{1'b1}} : (NUM_LANES'(1) << mem_addr[1:0]);
  assign wdata_nxt = (mem_op == OP_SB) ? sb_rep : mem_sdata;

  // mem_addr is held through DONE, so it still selects the right lane here.
  assign lane_byte = load_q[mem_addr[1:0]*VEC_W +: VEC_W];

  always_comb begin
    load_fmt = load_q;
    case (mem_op)
      OP_LB:   load_fmt = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_fmt = {24'h0, lane_byte};
      default: load_fmt = load_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      load_q     <= '0;
    end else begin
      case (state)
        IDLE: if (valid_acc) begin
          state      <= BUSY;
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_addr  <= {mem_addr[31:2], 2'b00};
          dbus_be    <= be_nxt;
          dbus_wdata <= wdata_nxt;
        end
        BUSY: if (dbus_ack) begin
          load_q   <= dbus_rdata;
          dbus_req <= 1'b0;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd    <= '0;
      wb_wdata <= '0;
      wb_wreg  <= 1'b0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (stallreq) begin
      wb_wreg  <= 1'b0;
      wb_whilo <= 1'b0;
    end else begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg && !(excp_adel || excp_ades);
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
      wb_wdata <= ((state == DONE) && is_load) ? load_fmt : mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus responder inline, MEM/WB results checked
// against a scoreboard of expected write-back entries.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_sdata;
  logic        mem_wreg, mem_whilo;
  logic [2:0]  mem_op;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        stallreq, excp_adel, excp_ades;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_wreg, wb_whilo;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_exp_t;

  wb_exp_t sb[$];
  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .stallreq(stallreq), .excp_adel(excp_adel), .excp_ades(excp_ades),
    .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op and service the bus; ack_after=0 means no bus access expected.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int ack_after,
                        input logic [4:0] wd, input logic [31:0] wdata, input logic wreg,
                        input logic [31:0] exp_wdata, input logic exp_wreg,
                        input logic [3:0] exp_be, input logic exp_we, input logic [31:0] exp_bwdata,
                        input int exp_stall, input logic exp_adel, input logic exp_ades);
    wb_exp_t e;
    int stall_cnt = 0;
    int busy = 0;
    bit done = 0;
    bit first = 1;
    bit stall_s;
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    mem_wd = wd; mem_wdata = wdata; mem_wreg = wreg;
    mem_whilo = wreg; mem_hi = wdata + 32'd1; mem_lo = wdata + 32'd2;
    e.wd = wd; e.wdata = exp_wdata; e.wreg = exp_wreg;
    e.whilo = wreg; e.hi = wdata + 32'd1; e.lo = wdata + 32'd2;
    sb.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (first) begin
        check({tag, " adel"}, excp_adel, exp_adel);
        check({tag, " ades"}, excp_ades, exp_ades);
        first = 0;
      end
      stall_s = stallreq;
      if (stall_s) stall_cnt++;
      if (dbus_req) begin
        busy++;
        if (busy == 1) begin
          check({tag, " be"}, dbus_be, exp_be);
          check({tag, " we"}, dbus_we, exp_we);
          check({tag, " addr"}, dbus_addr, {addr[31:2], 2'b00});
          if (exp_we) check({tag, " bus_wdata"}, dbus_wdata, exp_bwdata);
        end
        dbus_rdata = rdata;
        dbus_ack = (busy == ack_after);
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      if (!stall_s) begin
        e = sb.pop_front();
        check({tag, " wb_wd"}, wb_wd, e.wd);
        check({tag, " wb_wdata"}, wb_wdata, e.wdata);
        check({tag, " wb_wreg"}, wb_wreg, e.wreg);
        check({tag, " wb_whilo"}, wb_whilo, e.whilo);
        check({tag, " wb_hi"}, wb_hi, e.hi);
        check({tag, " wb_lo"}, wb_lo, e.lo);
        done = 1;
      end else begin
        check({tag, " bubble"}, wb_wreg, 1'b0);
      end
    end
    check({tag, " completed"}, done, 1'b1);
    check({tag, " stall_cycles"}, stall_cnt, exp_stall);
    check({tag, " bus_used"}, busy > 0, ack_after > 0);
  endtask

  initial begin
    rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    mem_op = '0; mem_addr = '0; mem_sdata = '0; mem_wd = '0; mem_wdata = '0;
    mem_wreg = 1'b0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst dbus_req", dbus_req, 1'b0);
    check("rst dbus_be", dbus_be, 4'h0);
    check("rst wb_wdata", wb_wdata, 32'h0);
    check("rst wb_wreg", wb_wreg, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    //     tag    op    addr          sdata         rdata         ack wd    wdata         wreg exp_wdata     ewreg be    we   bus_wdata     stall adel ades
    run_op("alu", 3'd0, 32'h0,        32'h0,        32'h0,        0,  5'd3, 32'h1234,     1,   32'h1234,     1,    4'h0, 0,   32'h0,        0,    0,   0);
    run_op("lw",  3'd1, 32'h100,      32'h0,        32'hDEADBEEF, 3,  5'd5, 32'h9,        1,   32'hDEADBEEF, 1,    4'hF, 0,   32'h0,        4,    0,   0);
    run_op("lb",  3'd2, 32'h103,      32'h0,        32'h80FFFFFF, 1,  5'd6, 32'h9,        1,   32'hFFFFFF80, 1,    4'h8, 0,   32'h0,        2,    0,   0);
    run_op("lbu", 3'd3, 32'h103,      32'h0,        32'h80FFFFFF, 2,  5'd7, 32'h9,        1,   32'h00000080, 1,    4'h8, 0,   32'h0,        3,    0,   0);
    run_op("lbp", 3'd2, 32'h100,      32'h0,        32'h1234567F, 1,  5'd8, 32'h9,        1,   32'h0000007F, 1,    4'h1, 0,   32'h0,        2,    0,   0);
    run_op("sb",  3'd5, 32'h201,      32'h000000A5, 32'h0,        1,  5'd9, 32'h77,       0,   32'h77,       0,    4'h2, 1,   32'hA5A5A5A5, 2,    0,   0);
    run_op("sw",  3'd4, 32'h300,      32'hCAFEF00D, 32'h0,        2,  5'd1, 32'h55,       0,   32'h55,       0,    4'hF, 1,   32'hCAFEF00D, 3,    0,   0);
    run_op("sw_mis", 3'd4, 32'h202,   32'h11,       32'h0,        0,  5'd2, 32'h66,       1,   32'h66,       0,    4'h0, 0,   32'h0,        0,    0,   1);
    run_op("lw_mis", 3'd1, 32'h101,   32'h0,        32'h0,        0,  5'd4, 32'h88,       1,   32'h88,       0,    4'h0, 0,   32'h0,        0,    1,   0);
    run_op("op7", 3'd7, 32'h3,        32'h0,        32'h0,        0,  5'd10, 32'hAB,      1,   32'hAB,       1,    4'h0, 0,   32'h0,        0,    0,   0);

    // Stray ack in IDLE must not start anything.
    mem_op = 3'd0;
    @(negedge clk); dbus_ack = 1'b1;
    @(posedge clk); #1; dbus_ack = 1'b0;
    check("idle_ack req", dbus_req, 1'b0);

    // Abort a load mid-BUSY with reset, then ack late.
    mem_op = 3'd1; mem_addr = 32'h400; mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'h42;
    for (int c = 0; c < 10 && !dbus_req; c++) @(posedge clk);
    check("abort reached busy", dbus_req, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort req", dbus_req, 1'b0);
    check("abort be", dbus_be, 4'h0);
    check("abort wb_wd", wb_wd, 5'd0);
    check("abort wb_wreg", wb_wreg, 1'b0);
    check("abort wb_wdata", wb_wdata, 32'h0);
    mem_op = 3'd0; mem_addr = '0; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
    #1;
    check("abort state idle", stallreq, 1'b0);
    @(negedge clk); rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; dbus_ack = 1'b0;
    @(negedge clk);
    check("late_ack req", dbus_req, 1'b0);
    check("late_ack stall", stallreq, 1'b0);
    check("late_ack wb_wdata", wb_wdata, 32'h0);
    @(posedge clk); #1;

    run_op("recover", 3'd1, 32'h500,  32'h0,        32'h0BADF00D, 1,  5'd13, 32'h1,       1,   32'h0BADF00D, 1,    4'hF, 0,   32'h0,        2,    0,   0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have inputs: mem_wd 5, mem_wdata 32, mem_wreg 1, mem_whilo 1, mem_hi 32, mem_lo 32; these are the memory-stage results from the EX/MEM register.
REQ-004 SHALL have inputs: mem_op 3 (0 none, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB, 6-7 treated as none), mem_addr 32, mem_sdata 32 (store data).
REQ-005 SHALL have bus outputs: dbus_req 1, dbus_we 1, dbus_addr 32, dbus_be 4, dbus_wdata 32.
REQ-006 SHALL have bus inputs: dbus_ack 1 (one-cycle completion), dbus_rdata 32 (valid with ack).
REQ-007 SHALL have outputs: stallreq 1 (hold upstream), excp_adel 1, excp_ades 1 (misaligned load/store).
REQ-008 SHALL have registered outputs: wb_wd 5, wb_wdata 32, wb_wreg 1, wb_whilo 1, wb_hi 32, wb_lo 32 (MEM/WB register).

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 An access is "valid" when mem_op is 1-5 and aligned: LW/SW need mem_addr[1:0]=0; byte ops are always aligned.
REQ-011 IDLE, valid access: next state BUSY; latch dbus_addr={mem_addr[31:2],2'b00}, dbus_we (1 for SW/SB), dbus_be, dbus_wdata; dbus_req=1 from next cycle.
REQ-012 IDLE, no valid access: remain IDLE; dbus_req=0.
REQ-013 BUSY: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata SHALL hold stable until the cycle dbus_ack=1.
REQ-014 BUSY with dbus_ack=1: capture dbus_rdata into an internal load register; dbus_req=0 next cycle; next state DONE.
REQ-015 DONE: unconditionally next state IDLE.
REQ-016 stallreq (combinational) SHALL be 1 in IDLE with a valid access and in BUSY; 0 in DONE and otherwise.
REQ-017 Byte enables: LW/SW 4'b1111; LB/LBU/SB 4'b0001 << mem_addr[1:0].
REQ-018 SB: dbus_wdata = mem_sdata[7:0] replicated to all four lanes; SW: mem_sdata.
REQ-019 Load data select (little-endian): lane = addr[1:0]; LB sign-extends, LBU zero-extends the selected byte; LW takes the full word.
REQ-020 Each cycle with stallreq=0: wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo <= mem_*; wb_wdata <= formatted load data in DONE for LW/LB/LBU, else mem_wdata.
REQ-021 Each cycle with stallreq=1: wb_wreg<=0, wb_whilo<=0 (bubble); other wb_* hold.
REQ-022 Misaligned LW (excp_adel) or SW (excp_ades): combinational 1 for that cycle; no bus access; no stall; wb_wreg<=0 on that edge.
REQ-023 Upstream SHALL hold mem_* stable while stallreq=1; the block relies on this and does not re-latch them.
REQ-024 dbus_ack while not BUSY SHALL be ignored.

Reset
REQ-025 rst=0 SHALL asynchronously force: state IDLE; dbus_req, dbus_we 0; dbus_addr, dbus_wdata, load register 0; dbus_be 0; all wb_* 0.
REQ-026 Reset asserted during BUSY SHALL abort the access (dbus_req falls immediately); a later ack SHALL be ignored.
REQ-027 First rising edge after rst returns to 1 SHALL behave as IDLE.

Verification
REQ-028 ALU op, mem_wd=3, mem_wdata=0x1234, mem_wreg=1 -> next edge wb_wd=3, wb_wdata=0x1234, wb_wreg=1; stallreq never 1.
REQ-029 LW addr 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> stallreq high 4 cycles, be=1111, wb_wdata=0xDEADBEEF with wb_wreg=1 after DONE; bubbles (wb_wreg=0) during stall.
REQ-030 LB addr 0x103, rdata 0x80FFFFFF -> be=1000, wb_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SB addr 0x201, sdata 0x000000A5 -> dbus_we=1, be=0010, wdata=0xA5A5A5A5, wb_wreg=0 if mem_wreg=0.
REQ-032 SW addr 0x202 -> excp_ades=1 one cycle, dbus_req stays 0, stallreq=0.
REQ-033 rst=0 mid-BUSY, then ack pulse -> dbus_req=0 immediately, all wb_* 0, FSM IDLE, ack ignored.
